dmem_dma_copier: RTL and testbench

- Bus initiator for the data memory's stall-handshake port (memread/memwrite/sign_mask/addr/write_data in; read_data/clk_stall out).
- Copies a block of 32-bit words from a source to a destination address in data memory, one read-then-write pair per word.
- Sits beside the core on the data-memory port. The core drives the port while this block is idle; an external mux selects this block while `busy` is high.

---
 rtl/dmem_dma_copier_pkg.sv | 18 +
 rtl/dmem_dma_copier_req_tracker.sv | 31 +++
 rtl/dmem_dma_copier.sv | 119 +++++++++++
 tb/tb_dmem_dma_copier.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_dma_copier_pkg.sv
// Shared definitions for the data-memory block copier: FSM states,
// the word-access sign_mask encoding and data-memory address landmarks.
package dmem_dma_copier_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_WR_WAIT,
    S_DONE
  } state_t;

  localparam logic [3:0]  WORD_SIGN_MASK = 4'b0100;
  localparam logic [31:0] DMEM_BASE      = 32'h0000_1000;
  localparam logic [31:0] LED_ADDR       = 32'h0000_2000;

endpackage

// File: rtl/dmem_dma_copier_req_tracker.sv
// Single-cycle request issue plus completion detection on the data memory's
// stall handshake: an access is finished once stall has risen and fallen again.
module dmem_req_tracker (
  input  logic clk,
  input  logic reset_n,
  input  logic issue,
  input  logic is_write,
  input  logic waiting,
  input  logic mem_stall,
  output logic mem_read,
  output logic mem_write,
  output logic complete
);

  logic seen_stall;

  assign mem_read  = issue & ~is_write;
  assign mem_write = issue &  is_write;
  assign complete  = waiting & seen_stall & ~mem_stall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seen_stall <= 1'b0;
    end else if (issue || complete) begin
      seen_stall <= 1'b0;
    end else if (waiting && mem_stall) begin
      seen_stall <= 1'b1;
    end
  end

endmodule

// File: rtl/dmem_dma_copier.sv
// Block copier on the data-memory stall-handshake port: one read then one
// write per 32-bit word, ascending addresses, misalignment flagged as error.
module dmem_dma_copier
  import dmem_dma_copier_pkg::*;
#(
  parameter int LEN_W  = 10,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [LEN_W-1:0]  words_left,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [3:0]        mem_sign_mask,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_stall
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [31:0]       data_q;
  logic              issue, is_write, waiting, complete;
  logic              misaligned;

  assign misaligned    = (|src_addr[1:0]) | (|dst_addr[1:0]);
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign mem_sign_mask = WORD_SIGN_MASK;
  assign mem_addr      = (state_q == S_RD_REQ) ? src_q :
                         (state_q == S_WR_REQ) ? dst_q : '0;
  assign mem_wdata     = (state_q == S_WR_REQ) ? data_q : '0;

  dmem_req_tracker u_tracker (
    .clk       (clk),
    .reset_n   (reset_n),
    .issue     (issue),
    .is_write  (is_write),
    .waiting   (waiting),
    .mem_stall (mem_stall),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .complete  (complete)
  );

  always_comb begin
    state_d  = state_q;
    issue    = 1'b0;
    is_write = 1'b0;
    waiting  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (misaligned || (len == '0)) state_d = S_DONE;
          else                           state_d = S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        // Hold off while the memory is still finishing a previous access.
        if (!mem_stall) begin
          issue   = 1'b1;
          state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        waiting = 1'b1;
        if (complete) state_d = S_WR_REQ;
      end
      S_WR_REQ: begin
        issue    = 1'b1;
        is_write = 1'b1;
        state_d  = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        waiting  = 1'b1;
        is_write = 1'b1;
        if (complete) state_d = (words_left == LEN_W'(1)) ? S_DONE : S_RD_REQ;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      data_q     <= '0;
      words_left <= '0;
      error      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) begin
        src_q      <= src_addr;
        dst_q      <= dst_addr;
        words_left <= len;
        error      <= misaligned;
      end
      if (state_q == S_RD_WAIT && complete) begin
        data_q <= mem_rdata;
      end
      if (state_q == S_WR_WAIT && complete) begin
        src_q      <= src_q + ADDR_W'(4);
        dst_q      <= dst_q + ADDR_W'(4);
        words_left <= words_left - LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dmem_dma_copier.sv
// Scoreboarded bench for dmem_dma_copier against a behavioural data memory
// that stalls for two cycles (plus an optional extra) after each request.
module tb_dmem_dma_copier;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] src_addr, dst_addr;
  logic [9:0]  len;
  logic        busy, done, error;
  logic [9:0]  words_left;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write, mem_stall;
  logic [3:0]  mem_sign_mask;

  int vectors = 0;
  int miscompares = 0;

  dmem_dma_copier #(.LEN_W(10), .ADDR_W(32)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .src_addr      (src_addr),
    .dst_addr      (dst_addr),
    .len           (len),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .words_left    (words_left),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_sign_mask (mem_sign_mask),
    .mem_rdata     (mem_rdata),
    .mem_stall     (mem_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural data memory
  logic [31:0] dmem [logic [31:0]];
  logic [31:0] rd_latch = '0;
  int          stall_cnt = 0;
  int          extra_stall = 0;

  assign mem_stall = (stall_cnt != 0);
  assign mem_rdata = rd_latch;

  always @(posedge clk) begin
    if (mem_read) begin
      rd_latch  <= dmem.exists(mem_addr) ? dmem[mem_addr] : 32'h0;
      stall_cnt <= 2 + extra_stall;
    end else if (mem_write) begin
      dmem[mem_addr] = mem_wdata;
      stall_cnt <= 2 + extra_stall;
    end else if (stall_cnt != 0) begin
      stall_cnt <= stall_cnt - 1;
    end
  end

  // Scoreboard queues and monitor
  logic [63:0] exp_wr [$];
  logic        exp_done [$];
  int          done_cnt = 0;
  logic        prev_rd = 1'b0;

  always @(negedge clk) begin
    if (mem_read && mem_write) chk("rd_wr_exclusive", 32'(mem_write), 32'h0);
    if (mem_read) chk("rd_width", 32'(prev_rd), 32'h0);
    prev_rd <= mem_read;
    if (mem_write) begin
      if (exp_wr.size() == 0) begin
        chk("unexpected_write", mem_addr, 32'hFFFF_FFFF);
      end else begin
        logic [63:0] e;
        e = exp_wr.pop_front();
        chk("wr_addr", mem_addr, e[63:32]);
        chk("wr_data", mem_wdata, e[31:0]);
      end
    end
    if (done) begin
      done_cnt++;
      if (exp_done.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'h0);
      end else begin
        logic e;
        e = exp_done.pop_front();
        chk("done_error", 32'(error), 32'(e));
      end
    end
  end

  logic [9:0] wl_seen [$];

  task automatic run_job(input logic [31:0] s, input logic [31:0] d, input logic [9:0] n,
                         input bit inject, output int done_i, output int first_rd,
                         output int nrd, output int nwr);
    done_i = -1; first_rd = -1; nrd = 0; nwr = 0;
    wl_seen.delete();
    src_addr = s; dst_addr = d; len = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (inject && i == 1) extra_stall = 0;
      if (inject && i == 2) begin start = 1'b1; src_addr = 32'h1004; len = 10'd7; end
      if (inject && i == 3) start = 1'b0;
      if (mem_read) begin
        nrd++;
        wl_seen.push_back(words_left);
        if (first_rd < 0) first_rd = i;
      end
      if (mem_write) nwr++;
      if (done) begin done_i = i; break; end
      @(negedge clk);
    end
    if (done_i < 0) chk("job_timeout", 32'hFFFF_FFFF, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int di, fr, nr, nw, dc;
    reset_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    dmem[32'h1000] = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_words_left", 32'(words_left), 0);
    chk("rst_mem_read", 32'(mem_read), 0);
    chk("rst_mem_write", 32'(mem_write), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("sign_mask", 32'(mem_sign_mask), 32'h4);
    reset_n = 1'b1;
    @(negedge clk);

    // Single word
    exp_wr.push_back({32'h1100, 32'hDEAD_BEEF});
    exp_done.push_back(1'b0);
    run_job(32'h1000, 32'h1100, 10'd1, 1'b0, di, fr, nr, nw);
    chk("t1_latency", 32'(di - fr), 32'd8);
    chk("t1_reads", 32'(nr), 1);
    chk("t1_writes", 32'(nw), 1);
    chk("t1_dmem", dmem[32'h1100], 32'hDEAD_BEEF);
    @(negedge clk);
    chk("t1_done_width", 32'(done), 0);
    chk("t1_busy_after", 32'(busy), 0);

    // Four words, ascending
    for (int k = 0; k < 4; k++) begin
      dmem[32'h1000 + 32'(4 * k)] = 32'(k + 1);
      exp_wr.push_back({32'h1200 + 32'(4 * k), 32'(k + 1)});
    end
    exp_done.push_back(1'b0);
    run_job(32'h1000, 32'h1200, 10'd4, 1'b0, di, fr, nr, nw);
    chk("t2_reads", 32'(nr), 4);
    chk("t2_cycles", 32'(di), 32'd32);
    for (int k = 0; k < 4 && k < wl_seen.size(); k++) chk("t2_words_left", 32'(wl_seen[k]), 32'(4 - k));
    chk("t2_words_left_end", 32'(words_left), 0);
    @(negedge clk);

    // Zero length
    exp_done.push_back(1'b0);
    run_job(32'h1000, 32'h1500, 10'd0, 1'b0, di, fr, nr, nw);
    chk("t3_done_at", 32'(di), 0);
    chk("t3_traffic", 32'(nr + nw), 0);
    @(negedge clk);

    // Misaligned source, then an aligned job clears error
    exp_done.push_back(1'b1);
    run_job(32'h1002, 32'h1600, 10'd2, 1'b0, di, fr, nr, nw);
    chk("t4_done_at", 32'(di), 0);
    chk("t4_traffic", 32'(nr + nw), 0);
    @(negedge clk);
    chk("t4_error_sticky", 32'(error), 1);
    src_addr = 32'h1000; dst_addr = 32'h1700; len = 10'd1; start = 1'b1;
    exp_wr.push_back({32'h1700, 32'hDEAD_BEEF});
    exp_done.push_back(1'b0);
    dmem[32'h1000] = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    chk("t4_error_cleared", 32'(error), 0);
    for (int i = 0; i < 50 && !done; i++) @(negedge clk);
    chk("t4b_done_seen", 32'(done), 1);
    @(negedge clk);

    // Start while busy plus a long stall on the first read
    dmem[32'h1020] = 32'h1111_2222;
    dmem[32'h1024] = 32'h3333_4444;
    exp_wr.push_back({32'h1120, 32'h1111_2222});
    exp_wr.push_back({32'h1124, 32'h3333_4444});
    exp_done.push_back(1'b0);
    extra_stall = 5;
    run_job(32'h1020, 32'h1120, 10'd2, 1'b1, di, fr, nr, nw);
    chk("t5_cycles", 32'(di), 32'd21);
    chk("t5_reads", 32'(nr), 2);
    @(negedge clk);

    // Async reset during the first WR_WAIT of a three-word job
    exp_wr.push_back({32'h1300, 32'h0000_0001});
    dc = done_cnt;
    src_addr = 32'h1000; dst_addr = 32'h1300; len = 10'd3; start = 1'b1;
    dmem[32'h1000] = 32'h0000_0001;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_busy", 32'(busy), 0);
    chk("t6_mem_write", 32'(mem_write), 0);
    chk("t6_mem_addr", mem_addr, 0);
    chk("t6_words_left", 32'(words_left), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6_no_done", 32'(done_cnt), 32'(dc));

    exp_wr.push_back({32'h1400, 32'h0000_0001});
    exp_done.push_back(1'b0);
    run_job(32'h1000, 32'h1400, 10'd1, 1'b0, di, fr, nr, nw);
    chk("t7_latency", 32'(di - fr), 32'd8);
    @(negedge clk);

    chk("sb_writes_drained", 32'(exp_wr.size()), 0);
    chk("sb_dones_drained", 32'(exp_done.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
